fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch front end for the pipelined successor of the single-cycle datapath.
//  Owns the PC and issues word requests to a latency-tolerant instruction memory.
//  Buffers returned instructions with their PCs in a DEPTH-entry in-order queue for decode.
//  Flushes the queue and in-flight fetches when a branch/jump/jalr redirect arrives.
// PARAMETERS
//  XLEN      32   PC / address width
//  DEPTH     4    queue entries (power of 2, >=2); also max allocated fetches
//  RESET_PC  0    PC after reset (word aligned)
// PORTS
//  clk             in   1          clock, all state on rising edge
//  rst             in   1          reset, asynchronous, active-high
//  imem_req_valid  out  1          fetch request valid
//  imem_req_ready  in   1          memory accepts request this cycle
//  imem_req_addr   out  XLEN       fetch address (fetch_pc)
//  imem_rsp_valid  in   1          instruction returned (in order, one per accepted req)
//  imem_rsp_data   in   32         returned instruction
//  redirect_valid  in   1          branch/jump taken: restart fetch
//  redirect_pc     in   XLEN       new PC; bits [1:0] forced to 0
//  dec_valid       out  1          head entry holds an instruction
//  dec_ready       in   1          decode consumes head this cycle
//  dec_inst        out  32         head instruction
//  dec_pc          out  XLEN       head PC
//  occupancy       out  clog2(DEPTH)+1  allocated entries (pending + filled)
// BEHAVIOUR
//  Reset: fetch_pc=RESET_PC, queue empty, drop_cnt=0, state RUN; outputs dec_valid=0,
//   imem_req_valid=0, imem_req_addr=RESET_PC, occupancy=0, dec_inst/dec_pc=0.
//  Request: imem_req_valid = !rst_q & (occupancy<DEPTH) & !redirect_valid. On accept
//   (valid&ready), an entry is allocated at tail with pc=fetch_pc, filled=0; fetch_pc+=4
//   (mod 2^XLEN, wraps silently).
//  Response: if drop_cnt!=0, the response is discarded and drop_cnt-=1; else it fills the
//   oldest unfilled entry. Responses never arrive in the accepting cycle (>=1 cycle later).
//  Decode: dec_valid = head.filled & !redirect_valid; dec_inst/dec_pc are registered head
//   fields. A response filling the head is visible on dec_* the next cycle (1-cycle latency
//   rsp->decode). Pop on dec_valid&dec_ready; accept and pop in the same cycle are allowed.
//   At full (occupancy==DEPTH), a same-cycle pop does not enable a request.
//  Redirect (priority over all same-cycle events): all entries cleared;
//   drop_cnt <= drop_cnt + (unfilled entries) - (imem_rsp_valid ? 1 : 0);
//   fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}; no request and no pop occur that cycle.
//   A response arriving in the redirect cycle is discarded.
//  FSM: RUN (drop_cnt==0) / DRAIN (drop_cnt!=0). DRAIN is entered on redirect with
//   in-flight fetches and left when drop_cnt reaches 0. New fetches from the redirect
//   target may be issued in DRAIN; their responses follow the dropped ones in order.
//  drop_cnt width clog2(DEPTH)+1, never exceeds DEPTH.
//  Reset mid-operation: immediate clear of all state. The memory shares rst and returns
//   nothing for pre-reset requests.
//  Counter/pointer widths: pointers clog2(DEPTH), wrap modulo DEPTH; occupancy is
//   computed from counters, not from pointer difference.
// TESTING
//  1 Reset, ready=1, rsp 1 cycle after accept with data=addr -> dec_pc 0,4,8,... back-to-back,
//    dec_inst==dec_pc, dec_valid is first seen 2 cycles after the first accept.
//  2 dec_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 accepts, occupancy=4, req_valid=0;
//    dec_ready=1 -> pops 0,4,8,C, fetch resumes at 0x10.
//  3 Three fetches in flight, redirect_pc=0x103 -> queue empty, the next 3 responses are
//    dropped (DRAIN), first dec_pc=0x100, no stale instruction reaches decode.
//  4 Redirect in the same cycle as rsp_valid and dec_ready -> the response is dropped, no pop,
//    drop_cnt = in-flight - 1, no request issued that cycle.
//  5 RESET_PC=32'hFFFF_FFF8 -> dec_pc FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
//  6 rst asserted mid-stream, asynchronous to clk -> dec_valid and req_valid go to 0 with no
//    clock edge, occupancy=0; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues word fetches and queues
// returned instructions with their PCs for decode; redirects flush and drain.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [XLEN-1:0]          imem_req_addr,
    input  logic                     imem_rsp_valid,
    input  logic [31:0]              imem_rsp_data,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output logic [31:0]              dec_inst,
    output logic [XLEN-1:0]          dec_pc,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {RUN, DRAIN} state_t;

    state_t            state, state_next;
    logic              rst_q;
    logic [XLEN-1:0]   fetch_pc;
    logic [PW-1:0]     head, tail, fill_ptr;
    logic [CW-1:0]     count, pend, drop_cnt, drop_next;
    logic [XLEN-1:0]   pc_mem   [DEPTH];
    logic [31:0]       inst_mem [DEPTH];
    logic [DEPTH-1:0]  filled;
    logic              acc, pop, fill, drop;
    logic              unused_ok;

    assign unused_ok      = ^redirect_pc[1:0];
    assign imem_req_addr  = fetch_pc;
    assign imem_req_valid = !rst_q && (count < CW'(DEPTH)) && !redirect_valid;
    assign dec_valid      = filled[head] && !redirect_valid;
    assign dec_inst       = inst_mem[head];
    assign dec_pc         = pc_mem[head];
    assign occupancy      = count;

    assign acc  = imem_req_valid && imem_req_ready;
    assign pop  = dec_valid && dec_ready;
    assign drop = imem_rsp_valid && (state == DRAIN);
    assign fill = imem_rsp_valid && (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            drop_cnt <= '0;
        end else begin
            state    <= state_next;
            drop_cnt <= drop_next;
        end
    end

    // Responses still owed for flushed fetches are counted and discarded.
    always_comb begin
        drop_next  = drop_cnt;
        state_next = state;
        if (redirect_valid)
            drop_next = drop_cnt + pend - CW'(imem_rsp_valid);
        else if (drop)
            drop_next = drop_cnt - CW'(1);
        unique case (state)
            RUN:   if (redirect_valid && drop_next != '0) state_next = DRAIN;
            DRAIN: if (drop_next == '0) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_q    <= 1'b1;
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            fill_ptr <= '0;
            count    <= '0;
            pend     <= '0;
            filled   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else begin
            rst_q <= 1'b0;
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
                head     <= '0;
                tail     <= '0;
                fill_ptr <= '0;
                count    <= '0;
                pend     <= '0;
                filled   <= '0;
            end else begin
                if (acc) begin
                    pc_mem[tail] <= fetch_pc;
                    filled[tail] <= 1'b0;
                    tail         <= tail + PW'(1);
                    fetch_pc     <= fetch_pc + XLEN'(4);
                end
                if (fill) begin
                    inst_mem[fill_ptr] <= imem_rsp_data;
                    filled[fill_ptr]   <= 1'b1;
                    fill_ptr           <= fill_ptr + PW'(1);
                end
                if (pop)
                    head <= head + PW'(1);
                count <= count + CW'(acc) - CW'(pop);
                pend  <= pend + CW'(acc) - CW'(fill);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, redirect/drain,
// PC wrap and asynchronous reset, against an in-order memory model.
module tb_fetch_unit;

    logic        clk, rst;
    logic        req_valid, req_ready, rsp_valid, redir_valid;
    logic [31:0] req_addr, rsp_data, redir_pc;
    logic        dv, dready;
    logic [31:0] dinst, dpc;
    logic [2:0]  occ;

    logic        w_req_valid, w_rsp_valid, w_dv;
    logic [31:0] w_req_addr, w_rsp_data, w_dinst, w_dpc;
    logic [2:0]  w_occ;

    logic        rsp_en;
    int          errors = 0, checks = 0, cyc = 0;
    int          acc_cnt, first_acc, first_dv;
    logic [31:0] mq[$], wq[$], accs[$], popped[$], popped_w[$];
    int          pop_cyc[$];

    fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid), .imem_req_ready(req_ready),
        .imem_req_addr(req_addr),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .redirect_valid(redir_valid), .redirect_pc(redir_pc),
        .dec_valid(dv), .dec_ready(dready),
        .dec_inst(dinst), .dec_pc(dpc), .occupancy(occ)
    );

    fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .rst(rst),
        .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
        .imem_req_addr(w_req_addr),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .dec_valid(w_dv), .dec_ready(1'b1),
        .dec_inst(w_dinst), .dec_pc(w_dpc), .occupancy(w_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // In-order memory: data = address, at least one cycle after accept.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            if (rsp_valid) void'(mq.pop_front());
            if (req_valid && req_ready) mq.push_back(req_addr);
            if (rsp_en && mq.size() > 0) begin
                rsp_valid <= 1'b1;
                rsp_data  <= mq[0];
            end else begin
                rsp_valid <= 1'b0;
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wq.delete();
            w_rsp_valid <= 1'b0;
            w_rsp_data  <= '0;
        end else begin
            if (w_rsp_valid) void'(wq.pop_front());
            if (w_req_valid) wq.push_back(w_req_addr);
            if (wq.size() > 0) begin
                w_rsp_valid <= 1'b1;
                w_rsp_data  <= wq[0];
            end else begin
                w_rsp_valid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (req_valid && req_ready) begin
                accs.push_back(req_addr);
                acc_cnt++;
                if (first_acc < 0) first_acc = cyc;
            end
            if (dv && first_dv < 0) first_dv = cyc;
            if (dv && dready) begin
                popped.push_back(dpc);
                pop_cyc.push_back(cyc);
                check("inst_eq_pc", dinst, dpc);
            end
            if (w_dv) popped_w.push_back(w_dpc);
        end
    end

    task automatic clear_logs();
        accs.delete();
        popped.delete();
        popped_w.delete();
        pop_cyc.delete();
        acc_cnt   = 0;
        first_acc = -1;
        first_dv  = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_logs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_acc(input int n);
        for (int i = 0; i < 50 && acc_cnt < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        req_ready = 1'b1;
        rsp_en = 1'b1;
        dready = 1'b1;
        redir_valid = 1'b0;
        redir_pc = '0;
        clear_logs();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_dv", dv, 0);
        check("rst_req", req_valid, 0);
        check("rst_addr", req_addr, 0);
        check("rst_occ", occ, 0);
        check("rst_inst", dinst, 0);
        check("rst_pc", dpc, 0);
        check("rst_addr_w", w_req_addr, 32'hFFFF_FFF8);
        rst = 1'b0;

        // 1: streaming
        repeat (16) @(posedge clk);
        #1;
        check("t1_npop", popped.size() >= 6, 1);
        for (int i = 0; i < 6; i++) begin
            check("t1_pc", popped[i], 32'(4 * i));
            check("t1_b2b", pop_cyc[i], pop_cyc[0] + i);
        end
        check("t1_lat", first_dv - first_acc, 2);

        // 5: PC wrap on the second instance
        check("t5_npop", popped_w.size() >= 3, 1);
        check("t5_pc0", popped_w[0], 32'hFFFF_FFF8);
        check("t5_pc1", popped_w[1], 32'hFFFF_FFFC);
        check("t5_pc2", popped_w[2], 32'h0000_0000);

        // 2: decode backpressure
        dready = 1'b0;
        do_reset();
        repeat (10) @(posedge clk);
        #1;
        check("t2_acc", acc_cnt, 4);
        check("t2_occ", occ, 4);
        check("t2_req", req_valid, 0);
        check("t2_dv", dv, 1);
        dready = 1'b1;
        @(negedge clk);
        check("t2_full_pop_noreq", req_valid, 0);
        repeat (10) @(posedge clk);
        #1;
        check("t2_npop", popped.size() >= 5, 1);
        for (int i = 0; i < 5; i++)
            check("t2_pc", popped[i], 32'(4 * i));
        check("t2_resume", accs[4], 32'h10);

        // 3: redirect with three fetches in flight
        rsp_en = 1'b0;
        do_reset();
        wait_acc(3);
        check("t3_acc", acc_cnt, 3);
        redir_valid = 1'b1;
        redir_pc = 32'h103;
        @(negedge clk);
        check("t3_noreq", req_valid, 0);
        @(posedge clk);
        #1;
        redir_valid = 1'b0;
        check("t3_occ", occ, 0);
        check("t3_drop", dut.drop_cnt, 3);
        check("t3_addr", req_addr, 32'h100);
        rsp_en = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("t3_npop", popped.size() >= 3, 1);
        for (int i = 0; i < 3; i++)
            check("t3_pc", popped[i], 32'h100 + 32'(4 * i));
        check("t3_drained", dut.drop_cnt, 0);

        // 4: redirect coinciding with response and dec_ready
        rsp_en = 1'b0;
        dready = 1'b0;
        do_reset();
        wait_acc(3);
        check("t4_acc", acc_cnt, 3);
        req_ready = 1'b0;
        rsp_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rsp_en = 1'b0;
        redir_valid = 1'b1;
        redir_pc = 32'h200;
        dready = 1'b1;
        @(negedge clk);
        check("t4_rsp", rsp_valid, 1);
        check("t4_head", dut.filled[0], 1);
        check("t4_dv", dv, 0);
        check("t4_req", req_valid, 0);
        @(posedge clk);
        #1;
        redir_valid = 1'b0;
        check("t4_nopop", popped.size(), 0);
        check("t4_drop", dut.drop_cnt, 1);
        check("t4_occ", occ, 0);
        req_ready = 1'b1;
        rsp_en = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("t4_npop", popped.size() >= 2, 1);
        check("t4_pc0", popped[0], 32'h200);
        check("t4_pc1", popped[1], 32'h204);

        // 6: asynchronous reset mid-stream
        do_reset();
        repeat (8) @(posedge clk);
        #2;
        check("t6_pre_dv", dv, 1);
        #1 rst = 1'b1;
        #1;
        check("t6_dv", dv, 0);
        check("t6_req", req_valid, 0);
        check("t6_occ", occ, 0);
        clear_logs();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("t6_nacc", accs.size() >= 1, 1);
        check("t6_acc0", accs[0], 32'h0);
        check("t6_npop", popped.size() >= 1, 1);
        check("t6_pop0", popped[0], 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
